// File: rtl/bus_pkg.sv
// Shared types and constants for the register-bus transfer controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package bus_pkg;

    // Controller phases; TURN is only reachable when the bus guard cycle is built in.
    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        DRIVE   = 3'd1,
        CAPTURE = 3'd2,
        ERR     = 3'd3,
        TURN    = 3'd4
    } xfer_state_t;

    localparam int NREG_DEF  = 4;
    localparam int WIDTH_DEF = 4;
    localparam int CNT_W     = 8;

    // A request is rejected when the destination does not exist, or when a
    // register source does not exist or would copy a register onto itself.
    function automatic logic xfer_illegal(input int src, input int dst,
                                          input logic imm, input int nreg);
        return (dst >= nreg) || (!imm && ((src >= nreg) || (src == dst)));
    endfunction

endpackage

// File: rtl/bus_onehot_dec.sv
// Index-to-one-hot decoder for register strobes; out-of-range index gives all zeros.
// Latency: combinational.
// Backpressure: none.
module bus_onehot_dec
    import bus_pkg::*;
#(
    parameter int NREG = NREG_DEF,
    parameter int SELW = $clog2(NREG)
) (
    input  logic [SELW-1:0] i_idx,
    input  logic            i_en,
    output logic [NREG-1:0] o_vec
);

    // Set exactly the selected bit when enabled, nothing otherwise.
    always_comb begin
        o_vec = '0;
        for (int i = 0; i < NREG; i++) begin
            if (i_en && (i_idx == SELW'(i))) begin
                o_vec[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_xfer_ctrl.sv
// Sequences non-overlapping oe/ie strobes for register and immediate bus transfers.
// Latency: accept at edge N -> drive N+1, capture/done N+2; err at N+1 (BUS_XFER_GUARD_EN adds a TURN cycle).
// Backpressure: req_ready is high only in IDLE; requests are held by the requester otherwise.
module bus_xfer_ctrl
    import bus_pkg::*;
#(
    parameter int NREG  = NREG_DEF,
    parameter int WIDTH = WIDTH_DEF,
    parameter int SELW  = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [SELW-1:0]  req_src,
    input  logic [SELW-1:0]  req_dst,
    input  logic             req_imm,
    input  logic [WIDTH-1:0] imm_data,
    output logic [NREG-1:0]  oe,
    output logic [NREG-1:0]  ie,
    output logic             ext_oe,
    output logic [WIDTH-1:0] ext_data,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] xfer_count
);

    xfer_state_t      r_state;
    xfer_state_t      w_next;
    logic [SELW-1:0]  r_src;
    logic [SELW-1:0]  r_dst;
    logic             r_imm;
    logic [WIDTH-1:0] r_imm_data;
    logic [CNT_W-1:0] r_xfer_count;

    logic             w_illegal;
    logic             w_take;
    logic             w_src_en;
    logic             w_dst_en;
    logic             w_ext_oe;

    assign w_illegal = xfer_illegal(int'(req_src), int'(req_dst), req_imm, NREG);
    assign w_take    = (r_state == IDLE) && req_valid;

    // State register; async reset parks the controller in IDLE so strobes drop at once.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and phase decode, purely from registered state (no req_* to strobe paths).
    always_comb begin
        w_next    = r_state;
        req_ready = 1'b0;
        w_src_en  = 1'b0;
        w_dst_en  = 1'b0;
        done      = 1'b0;
        err       = 1'b0;
        case (r_state)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    w_next = w_illegal ? ERR : DRIVE;
                end
            end
            DRIVE: begin
                w_src_en = 1'b1;
                w_next   = CAPTURE;
            end
            CAPTURE: begin
                w_src_en = 1'b1;
                w_dst_en = 1'b1;
                done     = 1'b1;
`ifdef BUS_XFER_GUARD_EN
                w_next   = TURN;
`else
                w_next   = IDLE;
`endif
            end
            ERR: begin
                err    = 1'b1;
                w_next = IDLE;
            end
            TURN: begin
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // Capture the request fields on accept; they steer the strobes for the whole transfer.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_src      <= '0;
            r_dst      <= '0;
            r_imm      <= 1'b0;
            r_imm_data <= '0;
        end else if (w_take) begin
            r_src      <= req_src;
            r_dst      <= req_dst;
            r_imm      <= req_imm;
            r_imm_data <= imm_data;
        end
    end

    // Count completed transfers; the 8-bit counter wraps naturally.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_xfer_count <= '0;
        end else if (r_state == CAPTURE) begin
            r_xfer_count <= r_xfer_count + CNT_W'(1);
        end
    end

    assign w_ext_oe   = w_src_en && r_imm;
    assign ext_oe     = w_ext_oe;
    assign ext_data   = w_ext_oe ? r_imm_data : '0;
    assign xfer_count = r_xfer_count;

    bus_onehot_dec #(
        .NREG (NREG),
        .SELW (SELW)
    ) u_oe_dec (
        .i_idx (r_src),
        .i_en  (w_src_en && !r_imm),
        .o_vec (oe)
    );

    bus_onehot_dec #(
        .NREG (NREG),
        .SELW (SELW)
    ) u_ie_dec (
        .i_idx (r_dst),
        .i_en  (w_dst_en),
        .o_vec (ie)
    );

endmodule

// File: tb/tb_bus_xfer_ctrl.sv
// Self-checking bench for bus_xfer_ctrl: cycle-offset reference model plus literal checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_bus_xfer_ctrl;

    localparam int NREG  = 4;
    localparam int WIDTH = 4;
    localparam int SELW  = 2;
`ifdef BUS_XFER_GUARD_EN
    localparam int P = 4;
`else
    localparam int P = 3;
`endif

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic [SELW-1:0]  req_src = '0;
    logic [SELW-1:0]  req_dst = '0;
    logic             req_imm = 1'b0;
    logic [WIDTH-1:0] imm_data = '0;
    logic [NREG-1:0]  oe;
    logic [NREG-1:0]  ie;
    logic             ext_oe;
    logic [WIDTH-1:0] ext_data;
    logic             done;
    logic             err;
    logic [7:0]       xfer_count;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    bus_xfer_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_src    (req_src),
        .req_dst    (req_dst),
        .req_imm    (req_imm),
        .imm_data   (imm_data),
        .oe         (oe),
        .ie         (ie),
        .ext_oe     (ext_oe),
        .ext_data   (ext_data),
        .done       (done),
        .err        (err),
        .xfer_count (xfer_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: cycles elapsed since the last accepted request decide everything.
    int         m_k     = 100;
    logic       m_err   = 1'b0;
    logic       m_imm   = 1'b0;
    int         m_src   = 0;
    int         m_dst   = 0;
    logic [3:0] m_data  = '0;
    int         m_count = 0;

    function automatic int busy_len(input logic e);
        return e ? 2 : P;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_k     = 100;
            m_err   = 1'b0;
            m_count = 0;
        end else begin
            if (!m_err && m_k == 2) m_count = (m_count + 1) % 256;
            if (m_k >= busy_len(m_err) && req_valid) begin
                m_k    = 1;
                m_src  = int'(req_src);
                m_dst  = int'(req_dst);
                m_imm  = req_imm;
                m_data = imm_data;
                m_err  = (m_dst >= NREG) || (!m_imm && ((m_src >= NREG) || (m_src == m_dst)));
            end else if (m_k < 100) begin
                m_k = m_k + 1;
            end
        end
    end

    // Compare every cycle, mid-cycle, while out of reset.
    always @(negedge clk) begin
        if (rst) begin
            logic       drv;
            logic [3:0] e_oe, e_ie;
            logic       e_ext;
            drv   = !m_err && (m_k == 1 || m_k == 2);
            e_oe  = (drv && !m_imm) ? (4'b0001 << m_src) : 4'b0000;
            e_ext = drv && m_imm;
            e_ie  = (!m_err && m_k == 2) ? (4'b0001 << m_dst) : 4'b0000;
            chk("m_ready",  32'(req_ready), 32'(m_k >= busy_len(m_err)));
            chk("m_oe",     32'(oe), 32'(e_oe));
            chk("m_ext_oe", 32'(ext_oe), 32'(e_ext));
            if (e_ext) chk("m_ext_data", 32'(ext_data), 32'(m_data));
            chk("m_ie",     32'(ie), 32'(e_ie));
            chk("m_done",   32'(done), 32'(!m_err && m_k == 2));
            chk("m_err",    32'(err), 32'(m_err && m_k == 1));
            chk("m_count",  32'(xfer_count), 32'(m_count));
            chk("inv_src",  32'(($countones(oe) + int'(ext_oe)) <= 1), 32'd1);
            chk("inv_ie",   32'($countones(ie) <= 1), 32'd1);
        end
    end

    task automatic present(input int s, input int d, input logic imm, input logic [3:0] data);
        @(negedge clk);
        req_src   = SELW'(s);
        req_dst   = SELW'(d);
        req_imm   = imm;
        imm_data  = data;
        req_valid = 1'b1;
    endtask

    initial begin
        int n;
        int d;
        // Reset values while held in reset
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(req_ready), 32'd1);
        chk("rst_oe", 32'(oe), 32'd0);
        chk("rst_ie", 32'(ie), 32'd0);
        chk("rst_ext_oe", 32'(ext_oe), 32'd0);
        chk("rst_ext_data", 32'(ext_data), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_count", 32'(xfer_count), 32'd0);
        rst = 1'b1;
        @(negedge clk);

        // Register transfer src=1 -> dst=2
        present(1, 2, 1'b0, 4'h0);
        @(negedge clk);                       // cycle N+1
        req_valid = 1'b0;
        chk("t1_oe_n1", 32'(oe), 32'h2);
        chk("t1_ie_n1", 32'(ie), 32'h0);
        chk("t1_ready_n1", 32'(req_ready), 32'd0);
        @(negedge clk);                       // cycle N+2
        chk("t1_oe_n2", 32'(oe), 32'h2);
        chk("t1_ie_n2", 32'(ie), 32'h4);
        chk("t1_done_n2", 32'(done), 32'd1);
        @(negedge clk);                       // cycle N+3
        chk("t1_count", 32'(xfer_count), 32'd1);
        chk("t1_oe_n3", 32'(oe), 32'h0);
`ifdef BUS_XFER_GUARD_EN
        chk("t1_ready_n3", 32'(req_ready), 32'd0);
        @(negedge clk);
        chk("t1_ready_n4", 32'(req_ready), 32'd1);
`else
        chk("t1_ready_n3", 32'(req_ready), 32'd1);
`endif

        // Immediate transfer A -> reg 3
        present(0, 3, 1'b1, 4'hA);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t2_ext_oe_n1", 32'(ext_oe), 32'd1);
        chk("t2_ext_data_n1", 32'(ext_data), 32'hA);
        chk("t2_oe_n1", 32'(oe), 32'h0);
        @(negedge clk);
        chk("t2_ext_oe_n2", 32'(ext_oe), 32'd1);
        chk("t2_ie_n2", 32'(ie), 32'h8);
        chk("t2_oe_n2", 32'(oe), 32'h0);
        @(negedge clk);
        chk("t2_count", 32'(xfer_count), 32'd2);
        repeat (P - 2) @(negedge clk);

        // Illegal register-to-itself request
        present(0, 0, 1'b0, 4'h0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t3_err_n1", 32'(err), 32'd1);
        chk("t3_oe_n1", 32'(oe), 32'h0);
        chk("t3_ie_n1", 32'(ie), 32'h0);
        @(negedge clk);
        chk("t3_ready_n2", 32'(req_ready), 32'd1);
        chk("t3_err_n2", 32'(err), 32'd0);
        chk("t3_count", 32'(xfer_count), 32'd2);

        // Immediate with src==dst is legal: source index is ignored
        present(3, 3, 1'b1, 4'h5);
        @(negedge clk);
        req_valid = 1'b0;
        chk("t4_err_n1", 32'(err), 32'd0);
        chk("t4_ext_data_n1", 32'(ext_data), 32'h5);
        @(negedge clk);
        chk("t4_done_n2", 32'(done), 32'd1);
        @(negedge clk);
        chk("t4_count", 32'(xfer_count), 32'd3);
        repeat (P - 2) @(negedge clk);

        // Reset in the middle of a transfer
        present(2, 1, 1'b0, 4'h0);
        @(posedge clk);                       // accept edge
        #2;
        chk("t5_oe_drive", 32'(oe), 32'h4);
        rst = 1'b0;
        #1;
        chk("t5_oe_rst", 32'(oe), 32'h0);
        chk("t5_ie_rst", 32'(ie), 32'h0);
        chk("t5_done_rst", 32'(done), 32'd0);
        chk("t5_count_rst", 32'(xfer_count), 32'd0);
        req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_ready_after", 32'(req_ready), 32'd1);
        chk("t5_done_after", 32'(done), 32'd0);

        // 256 back-to-back transfers with valid held: counter wraps to 0
        present(0, 3, 1'b0, 4'h0);
        n = 0;
        d = 0;
        while (d < 256 && n < 2000) begin
            @(negedge clk);
            n++;
            if (done) d++;
        end
        req_valid = 1'b0;
        chk("burst_done_cnt", 32'(d), 32'd256);
        chk("burst_cycles", 32'(n), 32'(2 + 255 * P));
        chk("burst_count_255", 32'(xfer_count), 32'd255);
        @(negedge clk);
        chk("burst_count_wrap", 32'(xfer_count), 32'd0);

        repeat (5) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/bus_xfer_ctrl.md
# bus_xfer_ctrl

Sequencing controller that sits directly upstream of the shared 4-bit register bus. It accepts register-to-register and immediate-to-register transfer requests over a valid/ready handshake. It drives the per-register output-enable and input-enable strobes in a fixed non-overlapping order, so that only one source ever drives the bus. It also reports completion, illegal requests and a running transfer count.

## Interface
Parameters:
- NREG, 4, number of registers attached to the bus (2..8)
- WIDTH, 4, bus data width
- SELW, $clog2(NREG), register index width

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- req_valid  in  1  transfer request present
- req_ready  out  1  controller can accept a request
- req_src  in  SELW  source register index (ignored when req_imm=1)
- req_dst  in  SELW  destination register index
- req_imm  in  1  source is imm_data instead of a register
- imm_data  in  WIDTH  immediate value
- oe  out  NREG  one-hot register output enables (bus drive)
- ie  out  NREG  one-hot register input enables (bus capture)
- ext_oe  out  1  immediate driver enable
- ext_data  out  WIDTH  immediate value held for the transfer
- done  out  1  one-cycle pulse, transfer completed
- err  out  1  one-cycle pulse, request rejected
- xfer_count  out  8  completed-transfer counter

## Operation
- States: IDLE, DRIVE, CAPTURE, ERR, plus TURN when the guard feature is compiled in.
- IDLE: req_ready=1 and all strobes are 0. When req_valid&&req_ready at a clock edge, the controller latches src, dst, imm and imm_data.
  - Illegal request → ERR. A request is illegal when req_dst>=NREG, or when req_imm=0 and (req_src>=NREG or req_src==req_dst).
  - Otherwise → DRIVE.
- DRIVE: the source drives the bus. For a register source, oe[src]=1. For an immediate, ext_oe=1 and ext_data=the latched value. ie=0. Next state is CAPTURE.
- CAPTURE: the source enable is held from DRIVE. ie[dst]=1 for exactly this cycle. done=1. xfer_count increments at the end of the cycle. Next state is TURN if the guard is compiled in, otherwise IDLE.
- ERR: err=1 and all strobes are 0. xfer_count is unchanged. Next state is IDLE.
- Invariants:
  - At most one bit set across oe and ext_oe combined.
  - At most one bit set in ie.
  - ie is never set without the matching source enable also set.
- Counter: xfer_count is 8-bit unsigned and wraps 255→0.
- req_ready=0 in every state except IDLE. Requests presented at that time are held by the requester and are not lost.
- All outputs are decoded from registered state and the latched fields, so there are no combinational paths from req_* to the strobes.

## Timing
- Reset values: req_ready=1; oe=0; ie=0; ext_oe=0; ext_data=0; done=0; err=0; xfer_count=0; state=IDLE.
- Reset mid-transfer: all strobes drop to 0 immediately and asynchronously. No done pulse is generated and the counter is cleared.
- Accept at edge N:
  - DRIVE during cycle N+1.
  - CAPTURE and done during cycle N+2.
  - req_ready=1 again in cycle N+3, or N+4 with the guard.
- Throughput: one transfer per 3 cycles, or 4 with the guard.
- Error latency: err is high during cycle N+1, and req_ready=1 in cycle N+2.
- Back-to-back requests: with req_valid held, the next request is accepted at the first edge where req_ready=1.

## Configuration
- BUS_XFER_GUARD_EN defined: after CAPTURE, the controller spends one TURN cycle with all strobes 0 and req_ready=0 before returning to IDLE. This guarantees one undriven bus cycle between successive drivers.
- BUS_XFER_GUARD_EN undefined: there is no TURN state, and CAPTURE goes directly to IDLE.

## Structure
- Package bus_pkg holds:
  - the state enum (IDLE, DRIVE, CAPTURE, ERR, TURN)
  - default NREG and WIDTH constants
  - the counter width constant (8)
- Sub-module bus_onehot_dec (index plus enable → one-hot NREG vector) is instantiated twice, once for oe and once for ie.

## Test plan
- Reset, then request src=1, dst=2, imm=0: oe=0010 in cycles N+1 and N+2; ie=0100 only in N+2; done in N+2; xfer_count=1.
- Immediate transfer imm_data=4'hA, dst=3: ext_oe=1 and ext_data=A in N+1 and N+2; ie=1000 in N+2; oe stays 0 throughout.
- Illegal request src=dst=0: err pulses in N+1; oe and ie stay 0; xfer_count unchanged; req_ready=1 in N+2.
- 256 back-to-back legal transfers with req_valid held: xfer_count wraps to 0; accepts occur every 3 cycles, or every 4 with BUS_XFER_GUARD_EN.
- Assert rst in cycle N+1 of a transfer: oe and ie drop to 0 before the next edge; no done pulse; req_ready=1 after rst deasserts.
- Every cycle in all tests: assertion that popcount(oe)+ext_oe≤1 and popcount(ie)≤1.
